data_mem_port: RTL and testbench

Handshaking data-memory port sitting directly downstream of the single-cycle MIPS datapath. It consumes the datapath's ALU result (address) and store data, runs a req/ack transaction against a variable-latency data memory, and returns load data to the datapath's `readdata` input. While a transaction is in flight it asserts `stall`, which freezes the PC register and suppresses register-file writes. It also flags misaligned word accesses and memory timeouts.

---
 rtl/mem_port_pkg.sv | 25 ++
 rtl/RegisterFF.sv | 29 ++
 rtl/timeout_counter.sv | 42 ++++
 rtl/data_mem_port.sv | 151 +++++++++++++++
 tb/tb_data_mem_port.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_pkg
// Shared definitions for the data-memory port of the single-cycle MIPS
// datapath.
//   state_t        : port FSM states (IDLE, REQ, DONE)
//   TIMEOUT_RDATA  : value returned to the datapath when a load times out
//   isAligned()    : word-alignment check on the low two address bits
// ---------------------------------------------------------------------------
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

    // Only the byte offset matters for a word access, so callers pass
    // addr[1:0] rather than the full address.
    function automatic logic isAligned(input logic [1:0] byteOffset);
        return (byteOffset == 2'b00);
    endfunction

endpackage

// File: rtl/RegisterFF.sv
// ---------------------------------------------------------------------------
// RegisterFF
// Generic D register with asynchronous active-high reset and load enable.
//   i_clk    : clock
//   i_reset  : asynchronous reset, loads RESET_VALUE
//   i_en     : load enable; register holds when low
//   i_d      : next value
//   o_q      : registered value
// ---------------------------------------------------------------------------
module RegisterFF #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_q <= RESET_VALUE;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
// Counts enabled cycles of an outstanding memory request and flags the cycle
// on which the LIMIT-th enabled cycle is in progress.
//   i_clk    : clock
//   i_reset  : asynchronous reset, clears the count
//   i_clear  : synchronous clear (start of a new request)
//   i_enable : count this cycle
//   o_hit    : this enabled cycle is the LIMIT-th one
// ---------------------------------------------------------------------------
module timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam int           CW        = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(LIMIT);
    localparam logic [CW-1:0] LAST      = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Saturates at LIMIT so a stuck enable can never wrap back to zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX_COUNT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // The count holds the number of already-completed enabled cycles, so
    // LIMIT-1 means the current cycle is the LIMIT-th.
    assign o_hit = i_enable && (r_count == LAST);

endmodule

// File: rtl/data_mem_port.sv
// ---------------------------------------------------------------------------
// data_mem_port
// Req/ack port between the single-cycle MIPS datapath and a variable-latency
// data memory. Stalls the datapath while an access is outstanding, flags
// misaligned word accesses and abandons accesses after TIMEOUT REQ cycles.
//   clk, reset          : clock, asynchronous active-high reset
//   memread, memwrite   : current instruction is lw / sw
//   addr, wdata         : byte address (aluResult) and store data
//   rdata               : load data back to the datapath (registered)
//   stall               : freeze PC and block regwrite (combinational)
//   misalign            : misaligned access seen in IDLE (combinational)
//   timeout_err         : access abandoned, high in the DONE cycle only
//   mem_req, mem_we     : memory request / write select (registered)
//   mem_addr, mem_wdata : word address and store data (registered)
//   mem_rdata, mem_ack  : memory read data and completion
// ---------------------------------------------------------------------------
module data_mem_port
    import mem_port_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t r_state;
    state_t w_nextState;

    logic w_access;
    logic w_aligned;
    logic w_start;
    logic w_hit;
    logic w_inReq;
    logic w_finish;
    logic w_timedOut;
    logic w_reqNext;
    logic w_rdataEn;
    logic r_timeoutFlag;
    logic [31:0] w_rdataNext;

    assign w_access  = memread | memwrite;
    assign w_aligned = isAligned(addr[1:0]);
    assign w_start   = (r_state == IDLE) && w_access && w_aligned;
    assign w_inReq   = (r_state == REQ);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE always returns to IDLE so a memread/memwrite
    // still held during the commit cycle cannot relaunch the same access.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = REQ;
            REQ:     if (mem_ack || w_hit) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic. An ack on the final allowed cycle completes normally,
    // so a timeout is only declared when the hit arrives without an ack.
    always_comb begin
        stall      = 1'b0;
        misalign   = 1'b0;
        w_finish   = 1'b0;
        w_timedOut = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    stall    = w_access && w_aligned;
                    misalign = w_access && !w_aligned;
                end
                REQ: begin
                    stall      = 1'b1;
                    w_finish   = mem_ack || w_hit;
                    w_timedOut = !mem_ack && w_hit;
                end
                default: ;
            endcase
        end
    end

    assign w_reqNext   = (w_nextState == REQ);
    assign w_rdataEn   = w_finish && !mem_we;
    assign w_rdataNext = mem_ack ? mem_rdata : TIMEOUT_RDATA;
    assign timeout_err = r_timeoutFlag;

    timeout_counter #(.LIMIT(TIMEOUT)) u_timeoutCounter (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clear  (w_start),
        .i_enable (w_inReq),
        .o_hit    (w_hit)
    );

    // Request attributes are captured once when leaving IDLE so they stay
    // stable across the whole REQ interval.
    RegisterFF #(.WIDTH(32)) u_memAddrReg (
        .i_clk(clk), .i_reset(reset), .i_en(w_start),
        .i_d({addr[31:2], 2'b00}), .o_q(mem_addr)
    );

    RegisterFF #(.WIDTH(32)) u_memWdataReg (
        .i_clk(clk), .i_reset(reset), .i_en(w_start),
        .i_d(wdata), .o_q(mem_wdata)
    );

    // Write wins when both memread and memwrite are set.
    RegisterFF #(.WIDTH(1)) u_memWeReg (
        .i_clk(clk), .i_reset(reset), .i_en(w_start),
        .i_d(memwrite), .o_q(mem_we)
    );

    RegisterFF #(.WIDTH(1)) u_memReqReg (
        .i_clk(clk), .i_reset(reset), .i_en(1'b1),
        .i_d(w_reqNext), .o_q(mem_req)
    );

    RegisterFF #(.WIDTH(32)) u_rdataReg (
        .i_clk(clk), .i_reset(reset), .i_en(w_rdataEn),
        .i_d(w_rdataNext), .o_q(rdata)
    );

    // Set only on the REQ->DONE transition, so it is high in DONE alone.
    RegisterFF #(.WIDTH(1)) u_timeoutFlagReg (
        .i_clk(clk), .i_reset(reset), .i_en(1'b1),
        .i_d(w_timedOut), .o_q(r_timeoutFlag)
    );

endmodule

// File: tb/tb_data_mem_port.sv
// ---------------------------------------------------------------------------
// tb_data_mem_port
// Directed bench for data_mem_port. dutA uses the default TIMEOUT and is
// driven from a per-cycle vector table; dutB uses TIMEOUT=3 for the timeout
// corner cases. A reset-mid-transaction sequence closes the run.
// ---------------------------------------------------------------------------
module tb_data_mem_port;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] mrd;
        logic        eStall;
        logic        eMis;
        logic        eReq;
        logic        eWe;
        logic        eTerr;
        logic [31:0] eRdata;
        logic [31:0] eMaddr;
        logic [31:0] eMwdata;
    } vec_t;

    localparam int NUM_VECS = 18;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memRdata;

    logic        readA, writeA, ackA;
    logic        stallA, misA, terrA, reqA, weA;
    logic [31:0] rdataA, maddrA, mwdA;

    logic        readB, ackB;
    logic        stallB, misB, terrB, reqB, weB;
    logic [31:0] rdataB, maddrB, mwdB;

    vec_t vecs [NUM_VECS];
    int   vectorCount = 0;
    int   missCount   = 0;

    data_mem_port dutA (
        .clk(clk), .reset(reset), .memread(readA), .memwrite(writeA),
        .addr(addr), .wdata(wdata), .rdata(rdataA), .stall(stallA),
        .misalign(misA), .timeout_err(terrA), .mem_req(reqA), .mem_we(weA),
        .mem_addr(maddrA), .mem_wdata(mwdA), .mem_rdata(memRdata),
        .mem_ack(ackA)
    );

    data_mem_port #(.TIMEOUT(3)) dutB (
        .clk(clk), .reset(reset), .memread(readB), .memwrite(1'b0),
        .addr(addr), .wdata(wdata), .rdata(rdataB), .stall(stallB),
        .misalign(misB), .timeout_err(terrB), .mem_req(reqB), .mem_we(weB),
        .mem_addr(maddrB), .mem_wdata(mwdB), .mem_rdata(memRdata),
        .mem_ack(ackB)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish by t=100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkSignal(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int i);
        readA    = vecs[i].rd;
        writeA   = vecs[i].wr;
        addr     = vecs[i].addr;
        wdata    = vecs[i].wdata;
        ackA     = vecs[i].ack;
        memRdata = vecs[i].mrd;
    endtask

    // mem_we is only meaningful while a request is outstanding.
    task automatic checkOutput(input int i);
        checkSignal($sformatf("v%0d.stall", i), stallA, vecs[i].eStall);
        checkSignal($sformatf("v%0d.misalign", i), misA, vecs[i].eMis);
        checkSignal($sformatf("v%0d.mem_req", i), reqA, vecs[i].eReq);
        if (vecs[i].eReq)
            checkSignal($sformatf("v%0d.mem_we", i), weA, vecs[i].eWe);
        checkSignal($sformatf("v%0d.timeout_err", i), terrA, vecs[i].eTerr);
        checkSignal($sformatf("v%0d.rdata", i), rdataA, vecs[i].eRdata);
        checkSignal($sformatf("v%0d.mem_addr", i), maddrA, vecs[i].eMaddr);
        checkSignal($sformatf("v%0d.mem_wdata", i), mwdA, vecs[i].eMwdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // rd wr addr wdata ack mrd | stall mis req we terr rdata maddr mwdata
        vecs[0]  = '{0,0,32'h00,32'h0,0,32'h0,         0,0,0,0,0, 32'h0,32'h0,32'h0};
        vecs[1]  = '{1,0,32'h10,32'h0,0,32'h0,         1,0,0,0,0, 32'h0,32'h0,32'h0};
        vecs[2]  = '{1,0,32'h10,32'h0,1,32'hCAFEF00D,  1,0,1,0,0, 32'h0,32'h10,32'h0};
        vecs[3]  = '{1,0,32'h10,32'h0,0,32'h0,         0,0,0,0,0, 32'hCAFEF00D,32'h10,32'h0};
        vecs[4]  = '{0,0,32'h00,32'h0,1,32'h99999999,  0,0,0,0,0, 32'hCAFEF00D,32'h10,32'h0};
        vecs[5]  = '{0,1,32'h20,32'h12345678,0,32'h0,  1,0,0,0,0, 32'hCAFEF00D,32'h10,32'h0};
        vecs[6]  = '{0,1,32'h20,32'h12345678,0,32'h0,  1,0,1,1,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[7]  = '{0,1,32'h20,32'h12345678,0,32'h0,  1,0,1,1,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[8]  = '{0,1,32'h20,32'h12345678,0,32'h0,  1,0,1,1,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[9]  = '{0,1,32'h20,32'h12345678,1,32'hDEADBEEF, 1,0,1,1,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[10] = '{0,1,32'h20,32'h12345678,0,32'h0,  0,0,0,1,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[11] = '{0,0,32'h00,32'h0,1,32'h77777777,  0,0,0,0,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[12] = '{1,0,32'h13,32'h0,0,32'h0,         0,1,0,0,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[13] = '{0,0,32'h13,32'h0,0,32'h0,         0,0,0,0,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[14] = '{1,1,32'h40,32'hAAAA5555,0,32'h0,  1,0,0,0,0, 32'hCAFEF00D,32'h20,32'h12345678};
        vecs[15] = '{1,1,32'h40,32'hAAAA5555,1,32'h11111111, 1,0,1,1,0, 32'hCAFEF00D,32'h40,32'hAAAA5555};
        vecs[16] = '{1,1,32'h40,32'hAAAA5555,0,32'h0,  0,0,0,1,0, 32'hCAFEF00D,32'h40,32'hAAAA5555};
        vecs[17] = '{0,0,32'h00,32'h0,0,32'h0,         0,0,0,0,0, 32'hCAFEF00D,32'h40,32'hAAAA5555};

        // Reset with a misaligned load presented: stall/misalign must stay low.
        reset = 1'b1; readA = 1'b1; writeA = 1'b0; ackA = 1'b0;
        readB = 1'b0; ackB = 1'b0;
        addr = 32'h13; wdata = 32'h0; memRdata = 32'h0;
        #3;
        checkSignal("rst.stall", stallA, 0);
        checkSignal("rst.misalign", misA, 0);
        checkSignal("rst.mem_req", reqA, 0);
        checkSignal("rst.mem_we", weA, 0);
        checkSignal("rst.timeout_err", terrA, 0);
        checkSignal("rst.rdata", rdataA, 0);
        checkSignal("rst.mem_addr", maddrA, 0);
        checkSignal("rst.mem_wdata", mwdA, 0);
        readA = 1'b0; addr = 32'h0;
        sample();
        sample();
        reset = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            tick();
            applyStimulus(i);
            sample();
            checkOutput(i);
        end
        tick();
        readA = 1'b0; writeA = 1'b0; ackA = 1'b0;

        // dutB: ack arrives on the third (final allowed) REQ cycle.
        readB = 1'b1; addr = 32'h100; ackB = 1'b0; memRdata = 32'h5A5A1234;
        sample();
        checkSignal("b3.idle.stall", stallB, 1);
        checkSignal("b3.idle.mem_req", reqB, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            ackB = (k == 3);
            sample();
            checkSignal($sformatf("b3.req%0d.mem_req", k), reqB, 1);
            checkSignal($sformatf("b3.req%0d.stall", k), stallB, 1);
        end
        tick();
        ackB = 1'b0;
        sample();
        checkSignal("b3.done.stall", stallB, 0);
        checkSignal("b3.done.mem_req", reqB, 0);
        checkSignal("b3.done.timeout_err", terrB, 0);
        checkSignal("b3.done.rdata", rdataB, 32'h5A5A1234);
        tick();
        readB = 1'b0;

        // dutB: no ack at all, then a late ack two cycles after DONE.
        tick();
        readB = 1'b1; addr = 32'h104;
        sample();
        checkSignal("bt.idle.stall", stallB, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            sample();
            checkSignal($sformatf("bt.req%0d.mem_req", k), reqB, 1);
            checkSignal($sformatf("bt.req%0d.timeout_err", k), terrB, 0);
        end
        tick();
        sample();
        checkSignal("bt.done.mem_req", reqB, 0);
        checkSignal("bt.done.stall", stallB, 0);
        checkSignal("bt.done.timeout_err", terrB, 1);
        checkSignal("bt.done.rdata", rdataB, 0);
        tick();
        readB = 1'b0;
        sample();
        checkSignal("bt.after.timeout_err", terrB, 0);
        tick();
        ackB = 1'b1; memRdata = 32'hFFFFFFFF;
        sample();
        checkSignal("bt.late.mem_req", reqB, 0);
        checkSignal("bt.late.stall", stallB, 0);
        tick();
        ackB = 1'b0;
        sample();
        checkSignal("bt.late.rdata", rdataB, 0);
        checkSignal("bt.late.timeout_err", terrB, 0);

        // dutA: reset lands in the second REQ cycle.
        tick();
        readA = 1'b1; addr = 32'h30;
        sample();
        checkSignal("rm.idle.stall", stallA, 1);
        tick();
        sample();
        checkSignal("rm.req1.mem_req", reqA, 1);
        tick();
        reset = 1'b1; readA = 1'b0;
        #1;
        checkSignal("rm.async.mem_req", reqA, 0);
        checkSignal("rm.async.stall", stallA, 0);
        sample();
        tick();
        sample();
        reset = 1'b0;
        #1;
        checkSignal("rm.post.rdata", rdataA, 0);
        checkSignal("rm.post.mem_addr", maddrA, 0);
        checkSignal("rm.post.mem_wdata", mwdA, 0);
        checkSignal("rm.post.mem_we", weA, 0);
        checkSignal("rm.post.mem_req", reqA, 0);
        checkSignal("rm.post.timeout_err", terrA, 0);
        checkSignal("rm.post.stall", stallA, 0);

        // Next load after reset completes normally.
        tick();
        readA = 1'b1; addr = 32'h44;
        sample();
        checkSignal("rn.idle.stall", stallA, 1);
        tick();
        ackA = 1'b1; memRdata = 32'hDEADBEEF;
        sample();
        checkSignal("rn.req.mem_req", reqA, 1);
        checkSignal("rn.req.mem_addr", maddrA, 32'h44);
        tick();
        ackA = 1'b0;
        sample();
        checkSignal("rn.done.rdata", rdataA, 32'hDEADBEEF);
        checkSignal("rn.done.stall", stallA, 0);
        checkSignal("rn.done.mem_req", reqA, 0);
        tick();
        readA = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
